// File: rtl/mem_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_arb_pkg : shared types and constants for the mem_arbiter SRAM sequencer |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
package mem_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD       = 3'd1,
    ST_WR_SETUP = 3'd2,
    ST_WR_PULSE = 3'd3,
    ST_WR_HOLD  = 3'd4
  } state_t;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_D  = 1'b1;

  // SRAM strobes are active-low; this is the idle level
  localparam logic STROBE_OFF = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mem_arb_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_arb_pick : combinational grant selection between fetch and data ports   |
// | Build option: MEM_ARB_RR_EN selects round-robin tie-break, else data wins   |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] eligible,
  input  logic       lastGrant,
  output logic       grantValid,
  output logic       grantPort
);

  always_comb begin
    grantValid = |eligible;
    if (eligible[PORT_D] && !eligible[PORT_IF]) begin
      grantPort = PORT_D;
    end else if (eligible[PORT_IF] && !eligible[PORT_D]) begin
      grantPort = PORT_IF;
    end else begin
`ifdef MEM_ARB_RR_EN
      // tie: the port that did not win last time goes first
      grantPort = ~lastGrant;
`else
      grantPort = PORT_D;
`endif
    end
  end

`ifndef MEM_ARB_RR_EN
  logic unused_last_grant;
  assign unused_last_grant = lastGrant;
`endif

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_arbiter : two-port arbiter and async SRAM sequencer (fetch + data port) |
// | Build option: MEM_ARB_RR_EN enables round-robin arbitration                 |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifReq,
  input  logic [15:0] ifAddr,
  output logic [15:0] ifData,
  output logic        ifAck,
  input  logic        dReq,
  input  logic        dWe,
  input  logic [15:0] dAddr,
  input  logic [15:0] dWdata,
  output logic [15:0] dRdata,
  output logic        dAck,
  output logic [15:0] addrBus,
  inout  wire  [15:0] dataBus,
  output logic        memRead,
  output logic        memWrite,
  output logic        memEnable,
  output logic        busy
);

  localparam logic [2:0] WAIT_LD = WAIT_CYCLES[2:0];

  state_t      state, state_nxt;
  logic [2:0]  cnt, cnt_nxt;
  logic        port_q, port_nxt;
  logic        last_grant, last_grant_nxt;
  logic [15:0] wdata_q, wdata_nxt;
  logic        drive_q, drive_nxt;
  logic [15:0] addr_nxt, if_data_nxt, d_rdata_nxt;
  logic        rd_n_nxt, wr_n_nxt, en_n_nxt, if_ack_nxt, d_ack_nxt;
  logic [1:0]  eligible;
  logic        grant_valid, grant_port;

  // a port that is being acked this cycle is not eligible for a new grant
  assign eligible = {dReq & ~dAck, ifReq & ~ifAck};

  mem_arb_pick u_pick (
    .eligible   (eligible),
    .lastGrant  (last_grant),
    .grantValid (grant_valid),
    .grantPort  (grant_port)
  );

  assign dataBus = drive_q ? wdata_q : 16'bz;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (grant_valid) begin
          state_nxt = (grant_port == PORT_D && dWe) ? ST_WR_SETUP : ST_RD;
        end
      end
      ST_RD:       if (cnt == 3'd0) state_nxt = ST_IDLE;
      ST_WR_SETUP: state_nxt = ST_WR_PULSE;
      ST_WR_PULSE: if (cnt == 3'd0) state_nxt = ST_WR_HOLD;
      ST_WR_HOLD:  state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    addr_nxt       = addrBus;
    wdata_nxt      = wdata_q;
    drive_nxt      = drive_q;
    rd_n_nxt       = memRead;
    wr_n_nxt       = memWrite;
    en_n_nxt       = memEnable;
    if_data_nxt    = ifData;
    d_rdata_nxt    = dRdata;
    if_ack_nxt     = 1'b0;
    d_ack_nxt      = 1'b0;
    cnt_nxt        = cnt;
    port_nxt       = port_q;
    last_grant_nxt = last_grant;
    case (state)
      ST_IDLE: begin
        if (grant_valid) begin
          port_nxt       = grant_port;
          last_grant_nxt = grant_port;
          addr_nxt       = (grant_port == PORT_D) ? dAddr : ifAddr;
          en_n_nxt       = 1'b0;
          cnt_nxt        = WAIT_LD;
          if (grant_port == PORT_D && dWe) begin
            wdata_nxt = dWdata;
            drive_nxt = 1'b1;
            wr_n_nxt  = STROBE_OFF;
          end else begin
            rd_n_nxt = 1'b0;
          end
        end
      end
      ST_RD: begin
        if (cnt != 3'd0) begin
          cnt_nxt = cnt - 3'd1;
        end else begin
          rd_n_nxt = STROBE_OFF;
          en_n_nxt = STROBE_OFF;
          if (port_q == PORT_D) begin
            d_rdata_nxt = dataBus;
            d_ack_nxt   = 1'b1;
          end else begin
            if_data_nxt = dataBus;
            if_ack_nxt  = 1'b1;
          end
        end
      end
      ST_WR_SETUP: begin
        wr_n_nxt = 1'b0;
        cnt_nxt  = WAIT_LD;
      end
      ST_WR_PULSE: begin
        if (cnt != 3'd0) begin
          cnt_nxt = cnt - 3'd1;
        end else begin
          wr_n_nxt = STROBE_OFF;
        end
      end
      ST_WR_HOLD: begin
        drive_nxt = 1'b0;
        en_n_nxt  = STROBE_OFF;
        d_ack_nxt = 1'b1;
      end
      default: begin
        drive_nxt = 1'b0;
        rd_n_nxt  = STROBE_OFF;
        wr_n_nxt  = STROBE_OFF;
        en_n_nxt  = STROBE_OFF;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addrBus    <= 16'h0000;
      wdata_q    <= 16'h0000;
      drive_q    <= 1'b0;
      memRead    <= STROBE_OFF;
      memWrite   <= STROBE_OFF;
      memEnable  <= STROBE_OFF;
      ifData     <= 16'h0000;
      dRdata     <= 16'h0000;
      ifAck      <= 1'b0;
      dAck       <= 1'b0;
      busy       <= 1'b0;
      cnt        <= 3'd0;
      port_q     <= PORT_IF;
      last_grant <= PORT_IF;
    end else begin
      addrBus    <= addr_nxt;
      wdata_q    <= wdata_nxt;
      drive_q    <= drive_nxt;
      memRead    <= rd_n_nxt;
      memWrite   <= wr_n_nxt;
      memEnable  <= en_n_nxt;
      ifData     <= if_data_nxt;
      dRdata     <= d_rdata_nxt;
      ifAck      <= if_ack_nxt;
      dAck       <= d_ack_nxt;
      busy       <= (state_nxt != ST_IDLE);
      cnt        <= cnt_nxt;
      port_q     <= port_nxt;
      last_grant <= last_grant_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_arbiter : scoreboard bench for mem_arbiter (W=1 main, W=0 boundary)  |
// | Honours MEM_ARB_RR_EN for the arbitration-order expectation                 |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_mem_arbiter;

  localparam int W  = 1;
  localparam int W0 = 0;

  typedef struct packed {
    logic        wr;
    logic [15:0] data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        ifReq, dReq, dWe, ifAck, dAck, memRead, memWrite, memEnable, busy;
  logic [15:0] ifAddr, dAddr, dWdata, ifData, dRdata, addrBus;
  wire  [15:0] dataBus;

  logic        z_ifReq, z_dReq, z_dWe, z_ifAck, z_dAck, z_memRead, z_memWrite, z_memEnable, z_busy;
  logic [15:0] z_ifAddr, z_dAddr, z_dWdata, z_ifData, z_dRdata, z_addrBus;
  wire  [15:0] z_dataBus;

  mem_arbiter #(.WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst),
    .ifReq(ifReq), .ifAddr(ifAddr), .ifData(ifData), .ifAck(ifAck),
    .dReq(dReq), .dWe(dWe), .dAddr(dAddr), .dWdata(dWdata), .dRdata(dRdata), .dAck(dAck),
    .addrBus(addrBus), .dataBus(dataBus),
    .memRead(memRead), .memWrite(memWrite), .memEnable(memEnable), .busy(busy)
  );

  mem_arbiter #(.WAIT_CYCLES(W0)) dut0 (
    .clk(clk), .rst(rst),
    .ifReq(z_ifReq), .ifAddr(z_ifAddr), .ifData(z_ifData), .ifAck(z_ifAck),
    .dReq(z_dReq), .dWe(z_dWe), .dAddr(z_dAddr), .dWdata(z_dWdata), .dRdata(z_dRdata), .dAck(z_dAck),
    .addrBus(z_addrBus), .dataBus(z_dataBus),
    .memRead(z_memRead), .memWrite(z_memWrite), .memEnable(z_memEnable), .busy(z_busy)
  );

  // released bus reads back as all ones
  pullup (dataBus);
  pullup (z_dataBus);

  function automatic logic [15:0] init_val(input logic [15:0] a);
    return (a == 16'h0040) ? 16'h1234 : ((a * 16'h9E37) ^ 16'h5A5A);
  endfunction

  // SRAM model for the main instance
  logic [15:0] sram [0:65535];
  bit          mem_init_done = 1'b0;
  assign dataBus = (!memEnable && !memRead) ? sram[addrBus] : 16'bz;
  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 65536; i++) sram[i] <= init_val(16'(i));
      mem_init_done <= 1'b1;
    end else if (!memEnable && !memWrite) begin
      sram[addrBus] <= dataBus;
    end
  end

  // boundary instance: read data is a fixed function of the address
  assign z_dataBus = (!z_memEnable && !z_memRead) ? (z_addrBus ^ 16'hA5A5) : 16'bz;

  // reference model: memory image as seen by completed-in-order data traffic
  logic [15:0] ref_mem [logic [15:0]];
  logic [15:0] exp_if [$];
  exp_t        exp_d [$];
  bit          ack_log [$];
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got ack, expected no ack", name);
  endtask

  function automatic logic [15:0] ref_read(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  task automatic push_exp(input bit pd, input bit we, input logic [15:0] a, input logic [15:0] wd);
    if (!pd) begin
      exp_if.push_back(ref_read(a));
    end else if (we) begin
      ref_mem[a] = wd;
      exp_d.push_back({1'b1, wd});
    end else begin
      exp_d.push_back({1'b0, ref_read(a)});
    end
  endtask

  task automatic set_port(input bit z, input bit pd, input logic req, input logic we,
                          input logic [15:0] a, input logic [15:0] wd);
    if (!z) begin
      if (pd) begin dReq = req; dWe = we; dAddr = a; dWdata = wd; end
      else    begin ifReq = req; ifAddr = a; end
    end else begin
      if (pd) begin z_dReq = req; z_dWe = we; z_dAddr = a; z_dWdata = wd; end
      else    begin z_ifReq = req; z_ifAddr = a; end
    end
  endtask

  function automatic logic ack_of(input bit z, input bit pd);
    return z ? (pd ? z_dAck : z_ifAck) : (pd ? dAck : ifAck);
  endfunction

  // One isolated transaction; k counts edges after the grant edge (k=0 is E0)
  task automatic single(input bit z, input bit pd, input bit we, input logic [15:0] a,
                        input logic [15:0] wd, output int ack_k, output int low_cnt,
                        output int bus_err, output logic [15:0] rd);
    logic        ack, rd_n, wr_n, en_n, bsy;
    logic [15:0] ab, db;
    if (!z) push_exp(pd, we, a, wd);
    set_port(z, pd, 1'b1, we, a, wd);
    ack_k = -1; low_cnt = 0; bus_err = 0; rd = 16'h0;
    for (int k = 0; k < 40 && ack_k < 0; k++) begin
      @(posedge clk); #1;
      ack  = ack_of(z, pd);
      rd_n = z ? z_memRead : memRead;
      wr_n = z ? z_memWrite : memWrite;
      en_n = z ? z_memEnable : memEnable;
      bsy  = z ? z_busy : busy;
      ab   = z ? z_addrBus : addrBus;
      db   = z ? z_dataBus : dataBus;
      if (ack) begin
        ack_k = k;
        rd = z ? (pd ? z_dRdata : z_ifData) : (pd ? dRdata : ifData);
        if (we && db !== 16'hFFFF) bus_err++;
      end else begin
        if (we ? (!wr_n && !en_n) : (!rd_n && !en_n)) low_cnt++;
        if (ab !== a) bus_err++;
        if (we && db !== wd) bus_err++;
        if (k == 0 && bsy !== 1'b1) bus_err++;
      end
      if (z && k == 0) set_port(z, pd, 1'b1, we, ~a, ~wd);
    end
    @(posedge clk); #1;
    set_port(z, pd, 1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic drive(input bit pd, input int n, input int maxgap);
    logic        we;
    logic [15:0] a, wd;
    int          k;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(maxgap, 0)) begin @(posedge clk); #1; end
      we = pd ? 1'($urandom_range(1, 0)) : 1'b0;
      a  = pd ? (16'h0100 + 16'($urandom_range(254, 0))) : 16'($urandom_range(255, 0));
      wd = 16'($urandom_range(32'hFFFE, 0));
      push_exp(pd, we, a, wd);
      set_port(1'b0, pd, 1'b1, we, a, wd);
      k = 0;
      do begin @(posedge clk); #1; k++; end while (!ack_of(1'b0, pd) && k < 80);
      check(pd ? "d_ack_timeout" : "if_ack_timeout", 32'(ack_of(1'b0, pd)), 32'd1);
      @(posedge clk); #1;
      set_port(1'b0, pd, 1'b0, 1'b0, 16'h0, 16'h0);
    end
  endtask

  // monitor: pops the scoreboard whenever an ack is presented
  logic [15:0] mon_if;
  exp_t        mon_d;
  always @(negedge clk) begin
    if (!rst) begin
      check("strobe_overlap", 32'(!memRead && !memWrite), 32'd0);
      if (ifAck) begin
        ack_log.push_back(1'b0);
        if (exp_if.size() == 0) fail_now("if_unexpected_ack");
        else begin
          mon_if = exp_if.pop_front();
          check("ifData", 32'(ifData), 32'(mon_if));
        end
      end
      if (dAck) begin
        ack_log.push_back(1'b1);
        if (exp_d.size() == 0) fail_now("d_unexpected_ack");
        else begin
          mon_d = exp_d.pop_front();
          if (!mon_d.wr) check("dRdata", 32'(dRdata), 32'(mon_d.data));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  int          ak, lc, be;
  logic [15:0] rdv;
  bit          exp_first;

  initial begin
    rst = 1'b1;
    set_port(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    set_port(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    set_port(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    set_port(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_addrBus",   32'(addrBus),   32'h0);
    check("rst_memRead",   32'(memRead),   32'h1);
    check("rst_memWrite",  32'(memWrite),  32'h1);
    check("rst_memEnable", 32'(memEnable), 32'h1);
    check("rst_acks",      32'({ifAck, dAck}), 32'h0);
    check("rst_rdata",     32'({ifData, dRdata}), 32'h0);
    check("rst_busy",      32'(busy),      32'h0);
    check("rst_dataBus",   32'(dataBus),   32'hFFFF);
    check("rst_z_busy",    32'({z_busy, z_memEnable, z_dataBus}), 32'h1FFFF);
    rst = 1'b0;
    @(posedge clk); #1;

    // fetch read 0x0040 and data write/read-back at 0x0100
    single(1'b0, 1'b0, 1'b0, 16'h0040, 16'h0, ak, lc, be, rdv);
    check("if_read_ack_edge", 32'(ak), 32'(W + 1));
    check("if_read_strobe_cycles", 32'(lc), 32'(W + 1));
    check("if_read_addr", 32'(be), 32'd0);
    single(1'b0, 1'b1, 1'b1, 16'h0100, 16'hBEEF, ak, lc, be, rdv);
    check("d_write_ack_edge", 32'(ak), 32'(W + 3));
    check("d_write_pulse_cycles", 32'(lc), 32'(W + 1));
    check("d_write_bus_stable", 32'(be), 32'd0);
    single(1'b0, 1'b1, 1'b0, 16'h0100, 16'h0, ak, lc, be, rdv);
    check("d_read_ack_edge", 32'(ak), 32'(W + 1));

    // contention from reset: continuous requests alternate starting with data
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0; @(posedge clk); #1;
    ack_log.delete();
    fork
      drive(1'b1, 3, 0);
      drive(1'b0, 3, 0);
    join
    check("cont_ack_count", 32'(ack_log.size()), 32'd6);
    for (int i = 0; i < ack_log.size() && i < 6; i++)
      check("cont_order", 32'(ack_log[i]), 32'((i % 2) == 0));

    // after a data grant, a tie shows the arbitration policy
    single(1'b0, 1'b1, 1'b1, 16'h0180, 16'h7777, ak, lc, be, rdv);
    ack_log.delete();
    fork
      drive(1'b1, 1, 0);
      drive(1'b0, 1, 0);
    join
`ifdef MEM_ARB_RR_EN
    exp_first = 1'b0;
`else
    exp_first = 1'b1;
`endif
    check("tie_ack_count", 32'(ack_log.size()), 32'd2);
    if (ack_log.size() > 0) check("tie_first_winner", 32'(ack_log[0]), 32'(exp_first));

    // randomized traffic on both ports
    fork
      drive(1'b1, 40, 3);
      drive(1'b0, 40, 3);
    join
    check("if_queue_drained", 32'(exp_if.size()), 32'd0);
    check("d_queue_drained", 32'(exp_d.size()), 32'd0);

    // reset in the middle of a write pulse
    set_port(1'b0, 1'b1, 1'b1, 1'b1, 16'h01FF, 16'h3C3C);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pulse_reached", 32'(memWrite), 32'd0);
    check("pulse_bus_driven", 32'(dataBus), 32'h3C3C);
    rst = 1'b1;
    #1;
    check("rst_mid_strobes", 32'({memRead, memWrite, memEnable}), 32'h7);
    check("rst_mid_dataBus", 32'(dataBus), 32'hFFFF);
    check("rst_mid_busy_ack", 32'({busy, dAck}), 32'h0);
    set_port(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("rst_mid_no_ack", 32'(dAck), 32'd0);

    // zero-wait instance, inputs scrambled after the grant edge
    single(1'b1, 1'b0, 1'b0, 16'h0222, 16'h0, ak, lc, be, rdv);
    check("w0_read_ack_edge", 32'(ak), 32'(W0 + 1));
    check("w0_read_strobe_cycles", 32'(lc), 32'(W0 + 1));
    check("w0_read_addr_held", 32'(be), 32'd0);
    check("w0_read_data", 32'(rdv), 32'(16'h0222 ^ 16'hA5A5));
    single(1'b1, 1'b1, 1'b1, 16'h0333, 16'h1111, ak, lc, be, rdv);
    check("w0_write_ack_edge", 32'(ak), 32'(W0 + 3));
    check("w0_write_pulse_cycles", 32'(lc), 32'(W0 + 1));
    check("w0_write_bus_held", 32'(be), 32'd0);
    single(1'b1, 1'b1, 1'b0, 16'h0444, 16'h0, ak, lc, be, rdv);
    check("w0_dread_ack_edge", 32'(ak), 32'(W0 + 1));
    check("w0_dread_data", 32'(rdv), 32'(16'h0444 ^ 16'hA5A5));

    repeat (3) @(posedge clk);
    check("final_if_queue", 32'(exp_if.size()), 32'd0);
    check("final_d_queue", 32'(exp_d.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
